// File: rtl/blink_rate_ctrl_if.sv
// blink_rate_ctrl_if: pushbutton input and rate/strobe outputs of the
// blinker rate controller.
//
// Signalling: there is no valid/ready handshake on this bus. KEY is a raw
// asynchronous level. tick and press are single-cycle strobes that the
// consumer must take on the cycle they are high; there is no backpressure.
// rate is a level that changes only on the cycle press is high, and only
// when the rate actually steps. dbg_state mirrors the debounce FSM state
// so that checkers can observe it.
interface blink_rate_ctrl_if;
  logic       KEY;
  logic       tick;
  logic [1:0] rate;
  logic       press;
  logic [1:0] dbg_state;

  modport master (output KEY, input tick, rate, press, dbg_state);
  modport slave  (input KEY, output tick, rate, press, dbg_state);
endinterface

// File: rtl/blink_rate_ctrl.sv
// blink_rate_ctrl: debounces an active-low pushbutton and steps through four
// blink rates on each accepted press. It emits a one-cycle tick every
// (BASE_DIV >> rate) cycles.
// Optional feature macro: BLINK_RATE_SATURATE_EN. When it is defined, rate
// stops at 3 instead of wrapping to 0. A press at rate 3 still pulses press
// but leaves the prescaler running.
module blink_rate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BASE_DIV        = 1_048_576
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  blink_rate_ctrl_if.slave   bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW = $clog2(BASE_DIV);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // BASE_DIV is a power of two, so BASE_DIV-1 is all ones. Shifting it right
  // by rate gives (BASE_DIV >> rate) - 1 directly.
  localparam logic [CW-1:0] PS_TOP  = CW'(BASE_DIV - 1);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic          sync1_q, sync2_q;
  logic          k;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          enter_held;
  logic          rate_step;
  logic [1:0]    rate_q, rate_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] term;
  logic          tick_q, tick_d;
  logic          press_q, press_d;

  // Two-flop synchronizer for the raw button; its idle (released) level is 1.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.KEY;
      sync2_q <= sync1_q;
    end
  end

  assign k = sync2_q;

  // Debounce FSM next state. Every state exit clears the counter, so it
  // never wraps. A press is accepted only on PRESS_WAIT -> HELD. Returning
  // to HELD from a bounce during release is not a new press.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    enter_held = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!k) begin
          state_d = S_PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (k) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DB_LAST) begin
          state_d    = S_HELD;
          dcnt_d     = '0;
          enter_held = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_HELD: begin
        if (k) begin
          state_d = S_RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (!k) begin
          state_d = S_HELD;
          dcnt_d  = '0;
        end else if (dcnt_q == DB_LAST) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        dcnt_d  = '0;
      end
    endcase
  end

`ifdef BLINK_RATE_SATURATE_EN
  // At rate 3 an accepted press leaves the rate and the prescaler untouched.
  assign rate_step = enter_held && (rate_q != 2'd3);
`else
  // Every accepted press steps the rate; 3 wraps to 0 in the 2-bit add.
  assign rate_step = enter_held;
`endif

  assign term = PS_TOP >> rate_q;

  // Rate, prescaler and strobe next state. A rate change restarts the
  // prescaler and suppresses a tick that would land on the same edge.
  always_comb begin
    rate_d  = rate_q;
    pcnt_d  = pcnt_q + CW'(1);
    tick_d  = 1'b0;
    press_d = enter_held;
    if (rate_step) begin
      rate_d = rate_q + 2'd1;
      pcnt_d = '0;
    end else if (pcnt_q == term) begin
      pcnt_d = '0;
      tick_d = 1'b1;
    end
  end

  // State registers; everything returns to its idle value on RESET.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      rate_q  <= 2'd0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      rate_q  <= rate_d;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      press_q <= press_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.rate      = rate_q;
  assign bus.press     = press_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// tb_blink_rate_ctrl: directed scenarios with DEBOUNCE_CYCLES=4, BASE_DIV=16.
// Expected tick/press events are {kind, rate, edge index since reset release}.
module tb_blink_rate_ctrl;

  localparam int W = 32;
  localparam logic [1:0] K_TICK  = 2'd1;
  localparam logic [1:0] K_PRESS = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic RESET;
  int   cyc;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edge counter since the last reset release, cleared together with the DUT.
  always @(posedge clk or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  blink_rate_ctrl_if bus ();

  blink_rate_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BASE_DIV       (16)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (RESET),
    .bus     (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [1:0] r, input int c);
    exp_q.push_back({kind, r, 28'(c)});
  endtask

  // Ticks at origin + n*period for edges strictly between lo and hi.
  task automatic push_ticks(input logic [1:0] r, input int origin, input int period,
                            input int lo, input int hi);
    for (int c = origin + period; c < hi; c += period)
      if (c > lo) push_ev(K_TICK, r, c);
  endtask

  task automatic check_event(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got unexpected event %h expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (!RESET) begin
      if (bus.press) check_event("press_event", {K_PRESS, bus.rate, 28'(cyc)});
      if (bus.tick)  check_event("tick_event",  {K_TICK,  bus.rate, 28'(cyc)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    RESET = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET   = 1'b1;
    bus.KEY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tick",  32'(bus.tick),      32'd0);
    check("reset_press", 32'(bus.press),     32'd0);
    check("reset_rate",  32'(bus.rate),      32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);

    // Phase A: idle cadence, bounce rejection, four clean presses.
    push_ticks(2'd0, 0, 16, 0, 137);
    push_ev(K_PRESS, 2'd1, 137);
    push_ticks(2'd1, 137, 8, 137, 157);
    push_ev(K_PRESS, 2'd2, 157);
    push_ticks(2'd2, 157, 4, 157, 177);
    push_ev(K_PRESS, 2'd3, 177);
    push_ticks(2'd3, 177, 2, 177, 197);
`ifdef BLINK_RATE_SATURATE_EN
    push_ev(K_PRESS, 2'd3, 197);
    push_ticks(2'd3, 177, 2, 196, 221);
`else
    push_ev(K_PRESS, 2'd0, 197);
    push_ticks(2'd0, 197, 16, 197, 221);
`endif
    release_reset();

    wait_cyc(100); bus.KEY = 1'b0;
    wait_cyc(103); bus.KEY = 1'b1;
    wait_cyc(104); bus.KEY = 1'b0;
    wait_cyc(107); bus.KEY = 1'b1;
    wait_cyc(130); check("no_press_after_bounce_rate", 32'(bus.rate), 32'd0);
    for (int n = 0; n < 4; n++) begin
      wait_cyc(130 + 20 * n); bus.KEY = 1'b0;
      wait_cyc(140 + 20 * n); bus.KEY = 1'b1;
    end
    wait_cyc(220);
`ifdef BLINK_RATE_SATURATE_EN
    check("rate_after_four", 32'(bus.rate), 32'd3);
`else
    check("rate_after_four", 32'(bus.rate), 32'd0);
`endif
    RESET = 1'b1;
    check("phaseA_drained", 32'(exp_q.size()), 32'd0);

    // Phase B: reach rate 2, then reset during PRESS_WAIT.
    push_ticks(2'd0, 0, 16, 0, 17);
    push_ev(K_PRESS, 2'd1, 17);
    push_ticks(2'd1, 17, 8, 17, 37);
    push_ev(K_PRESS, 2'd2, 37);
    push_ticks(2'd2, 37, 4, 37, 55);
    release_reset();
    wait_cyc(10); bus.KEY = 1'b0;
    wait_cyc(20); bus.KEY = 1'b1;
    wait_cyc(30); bus.KEY = 1'b0;
    wait_cyc(40); bus.KEY = 1'b1;
    wait_cyc(50); bus.KEY = 1'b0;
    wait_cyc(54);
    check("prewait_state", 32'(bus.dbg_state), 32'd1);
    check("prewait_rate",  32'(bus.rate),      32'd2);
    #1 RESET = 1'b1;
    #1;
    check("async_rst_rate",  32'(bus.rate),      32'd0);
    check("async_rst_tick",  32'(bus.tick),      32'd0);
    check("async_rst_press", 32'(bus.press),     32'd0);
    check("async_rst_state", 32'(bus.dbg_state), 32'd0);
    check("phaseB_drained",  32'(exp_q.size()),  32'd0);

    // Phase C: KEY still low needs a full debounce; then a press whose
    // HELD entry lands on the prescaler terminal count (edge 39).
    push_ev(K_PRESS, 2'd1, 7);
    push_ticks(2'd1, 7, 8, 7, 39);
    push_ev(K_PRESS, 2'd2, 39);
    push_ticks(2'd2, 39, 4, 39, 61);
    @(posedge clk);
    release_reset();
    wait_cyc(10); bus.KEY = 1'b1;
    wait_cyc(32); bus.KEY = 1'b0;
    wait_cyc(42); bus.KEY = 1'b1;
    wait_cyc(60);
    check("final_rate", 32'(bus.rate), 32'd2);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/blink_rate_ctrl.md
# blink_rate_ctrl

Upstream stage for the board's LED blinker. Takes a raw, bouncing active-low pushbutton on the 50 MHz clock domain, debounces it, and uses each confirmed press to step through four blink rates. Emits a single-cycle `tick` enable at the selected rate; the downstream blinker toggles its LED state on each `tick` instead of tapping a fixed free-running counter bit.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a press or release (20 ms at 50 MHz); minimum 2.
- `BASE_DIV`, default 1_048_576: tick period in cycles at rate 0; power of two, minimum 16.
- `CLOCK_50`  in  1  system clock, 50 MHz, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `KEY`  in  1  raw pushbutton, active-low, asynchronous to `CLOCK_50`.
- `tick`  out  1  one-cycle pulse, period `BASE_DIV >> rate` cycles.
- `rate`  out  2  current rate index; 0 is slowest, 3 is fastest.
- `press`  out  1  one-cycle pulse on each accepted press.

## Operation
- `KEY` passes through a 2-flop synchronizer; its reset value is 1 (released). All downstream logic uses the synchronized value `k`.
- Debounce FSM states and transitions:
  - IDLE: `k`=0 → PRESS_WAIT with the debounce counter at 0.
  - PRESS_WAIT: `k`=1 → IDLE, counter cleared. `k`=0 while the counter equals `DEBOUNCE_CYCLES-1` → HELD. Otherwise the counter increments.
  - HELD: `k`=1 → RELEASE_WAIT with the counter at 0.
  - RELEASE_WAIT: `k`=0 → HELD, counter cleared. `k`=1 while the counter equals `DEBOUNCE_CYCLES-1` → IDLE. Otherwise the counter increments.
- On the edge entering HELD:
  - `press` is registered high for exactly one cycle.
  - `rate` becomes `rate+1` mod 4 (3 wraps to 0).
- Prescaler:
  - Counter width is `$clog2(BASE_DIV)`.
  - Terminal count `T = (BASE_DIV >> rate) - 1`.
  - When the counter equals `T`, it returns to 0 and `tick` is registered high for one cycle. Otherwise it increments.
- Rate change (HELD entry edge):
  - The prescaler counter is forced to 0.
  - `tick` is forced low on that edge, even if the counter was at `T`. The rate change wins.
  - The first tick at the new rate arrives `BASE_DIV >> rate_new` cycles later.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES)`. It never wraps because it is cleared on every state exit.

## Timing
- Reset values: FSM=IDLE, both counters 0, sync flops 1, `rate`=0, `tick`=0, `press`=0.
- `RESET` asserted mid-operation clears everything immediately, without waiting for a clock edge. The first tick after deassertion arrives after `BASE_DIV` cycles.
- Latency from the `KEY` falling edge to `press` high:
  - 2 cycles of synchronizer, plus
  - `DEBOUNCE_CYCLES` cycles of stable low, plus
  - 1 registered edge.
  - Bench formula: `press` high on edge `DEBOUNCE_CYCLES+2` after the first sampled low.
- Any bounce restarts the full debounce window.
- A press held indefinitely yields exactly one `press` pulse.
- `tick` and `press` are never high for two consecutive cycles. Exception: `tick` at rate 3 with `BASE_DIV`=16 has period 2 and is never adjacent.
- All outputs are registered. There is no combinational path from `KEY` to any output.

## Configuration
- `BLINK_RATE_SATURATE_EN` defined: `rate` increments up to 3 and then holds at 3.
  - A press at rate 3 still pulses `press`.
  - A press at rate 3 does not change `rate` and does not clear the prescaler. The tick cadence continues uninterrupted.
- `BLINK_RATE_SATURATE_EN` undefined: `rate` wraps 3→0 as described in Operation.

## Test plan
Directed scenarios run with `DEBOUNCE_CYCLES`=4 and `BASE_DIV`=16.
- Reset, then `KEY`=1 held for 100 cycles → `tick` every 16 cycles, first on the 16th edge after reset release; `rate`=0; `press` never asserted.
- `KEY` driven low and held → `press` is one pulse on edge 6 after the first low sample. `rate` goes 0→1. Tick period becomes 8, with the first tick 8 cycles after the change.
- `KEY` low for 3 cycles, high for 1, low for 3, then high → no `press`, `rate` stays 0, tick cadence unbroken.
- Four clean press/release cycles, each low and high for 10 cycles → `rate` sequence 1,2,3,0 with tick periods 8,4,2,16. With `BLINK_RATE_SATURATE_EN` defined, the sequence is 1,2,3,3 with 4 `press` pulses.
- Rate change timed so HELD entry coincides with prescaler count=`T` → no `tick` on that edge; counter restarts at 0.
- `RESET` pulsed for 1 cycle while in PRESS_WAIT with `rate`=2 → outputs go to 0 immediately. After release, `KEY` still low must complete a fresh full debounce before `press` fires.
